// File: rtl/i2c_master_core_if.sv
// i2c_master_core_if: the register-side and pad-side signals of the I2C master core.
// The master modport is the core's view. The slave modport is the view of the register
// block and pads that surround the core.
interface i2c_master_core_if;
    logic [7:0] prescale_reg;
    logic [7:0] address_reg;
    logic [7:0] transmit_reg;
    logic [7:0] command_reg;
    logic       cmd_wr;
    logic [7:0] status_reg;
    logic [7:0] receive_reg;
    logic       scl_o;
    logic       sda_oe;
    logic       sda_i;
    logic       scl_i;

    modport master (
        input  prescale_reg, address_reg, transmit_reg, command_reg, cmd_wr, sda_i, scl_i,
        output status_reg, receive_reg, scl_o, sda_oe
    );

    modport slave (
        output prescale_reg, address_reg, transmit_reg, command_reg, cmd_wr, sda_i, scl_i,
        input  status_reg, receive_reg, scl_o, sda_oe
    );
endinterface

// File: rtl/i2c_master_core.sv
// i2c_master_core: single-byte I2C master. It sends START, the address, then one byte
// (write) or receives one byte (read, answered with NACK), and finishes with STOP.
// Every SCL bit is four prescaler ticks: SCL is low in phases 0-1 and high in phases 2-3.
// Optional feature: define I2C_CLOCK_STRETCH_EN to freeze the high phases while a slave
// holds SCL low.
module i2c_master_core (
    input  logic              PCLK,
    input  logic              PRESET,
    i2c_master_core_if.master bus
);
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] START     = 4'd1;
    localparam logic [3:0] ADDR      = 4'd2;
    localparam logic [3:0] ADDR_ACK  = 4'd3;
    localparam logic [3:0] WRITE     = 4'd4;
    localparam logic [3:0] WRITE_ACK = 4'd5;
    localparam logic [3:0] READ      = 4'd6;
    localparam logic [3:0] READ_ACK  = 4'd7;
    localparam logic [3:0] STOP      = 4'd8;

    logic [3:0] state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] rx_q, rx_d;
    logic       done_q, done_d;
    logic       nack_q, nack_d;
    logic       rxv_q, rxv_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       busy, hold, tick, slotEnd, samplePoint;
    logic       unusedBits;

    assign busy = (state_q != IDLE);

`ifdef I2C_CLOCK_STRETCH_EN
    assign hold = scl_q && !bus.scl_i && phase_q[1];
`else
    assign hold = 1'b0;
`endif

    // The low seven command bits are reserved. Without stretching, scl_i has no function.
    assign unusedBits = ^{bus.command_reg[6:0], bus.scl_i};

    // The comparison uses >= so that lowering the prescaler mid-count cannot wrap the counter.
    assign tick        = busy && !hold && (cnt_q >= bus.prescale_reg);
    assign slotEnd     = tick && (phase_q == 2'd3);
    assign samplePoint = tick && (phase_q == 2'd2);

    assign bus.status_reg  = {4'b0000, nack_q, busy, done_q, rxv_q};
    assign bus.receive_reg = rx_q;
    assign bus.scl_o       = scl_q;
    assign bus.sda_oe      = sda_q;

    // Next-state logic for the bit timer and the transfer sequencer; pad levels follow the next state
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rx_d     = rx_q;
        done_d   = done_q;
        nack_d   = nack_q;
        rxv_d    = rxv_q;
        scl_d    = 1'b1;
        sda_d    = 1'b0;

        if (!busy) begin
            cnt_d = 8'd0;
        end else if (!hold) begin
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
        end
        if (tick) begin
            phase_d = phase_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_wr && bus.command_reg[7]) begin
                    state_d = START;
                    phase_d = 2'd0;
                    cnt_d   = 8'd0;
                    addr_d  = bus.address_reg;
                    data_d  = bus.transmit_reg;
                    done_d  = 1'b0;
                    nack_d  = 1'b0;
                    rxv_d   = 1'b0;
                end
            end
            START: begin
                if (slotEnd) begin
                    state_d  = ADDR;
                    shift_d  = addr_q;
                    bitcnt_d = 3'd0;
                end
            end
            ADDR, WRITE: begin
                if (slotEnd) begin
                    if (bitcnt_q == 3'd7) begin
                        state_d = (state_q == ADDR) ? ADDR_ACK : WRITE_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            ADDR_ACK: begin
                if (samplePoint && bus.sda_i) begin
                    nack_d = 1'b1;
                end
                if (slotEnd) begin
                    bitcnt_d = 3'd0;
                    if (nack_q) begin
                        state_d = STOP;
                    end else if (addr_q[0]) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                        shift_d = data_q;
                    end
                end
            end
            WRITE_ACK: begin
                if (samplePoint && bus.sda_i) begin
                    nack_d = 1'b1;
                end
                if (slotEnd) begin
                    state_d = STOP;
                end
            end
            READ: begin
                if (samplePoint) begin
                    shift_d = {shift_q[6:0], bus.sda_i};
                end
                if (slotEnd) begin
                    if (bitcnt_q == 3'd7) begin
                        state_d = READ_ACK;
                        rx_d    = shift_q;
                        rxv_d   = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            READ_ACK: begin
                if (slotEnd) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (slotEnd) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            IDLE: begin
                scl_d = 1'b1;
                sda_d = 1'b0;
            end
            START: begin
                scl_d = 1'b1;
                sda_d = phase_d[1];
            end
            ADDR, WRITE: begin
                scl_d = phase_d[1];
                sda_d = ~shift_d[7];
            end
            STOP: begin
                scl_d = phase_d[1];
                sda_d = (phase_d != 2'd3);
            end
            default: begin
                scl_d = phase_d[1];
                sda_d = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any transfer and releases both lines without a STOP
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= IDLE;
            phase_q  <= 2'd0;
            cnt_q    <= 8'd0;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'd0;
            addr_q   <= 8'd0;
            data_q   <= 8'd0;
            rx_q     <= 8'd0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
            rxv_q    <= 1'b0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rx_q     <= rx_d;
            done_q   <= done_d;
            nack_q   <= nack_d;
            rxv_q    <= rxv_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
        end
    end
endmodule

// File: tb/tb_i2c_master_core.sv
// tb_i2c_master_core: table-driven bench for the I2C master core. A bus monitor compares
// every SDA bit seen on a rising SCL edge against a queue of expected bits that is filled
// when each transfer is launched. A simple slave pulls SDA low as the table prescribes.
module tb_i2c_master_core;
    typedef struct {
        logic [7:0] prescale;
        logic [7:0] addr;
        logic [7:0] tx;
        logic [7:0] slaveByte;
        logic       ackAddr;
        logic       ackData;
    } vec_t;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        slavePull = 1'b0;
    logic        stretch = 1'b0;
    logic        monEnable = 1'b0;
    logic        checkPeriod = 1'b1;
    logic [31:0] pullMask = '0;
    logic        expQ[$];
    logic [7:0]  expStatus;
    logic [7:0]  lastRx = 8'h00;
    logic [7:0]  curPrescale = 8'd0;
    int          nVec = 0;
    int          nMiss = 0;
    int          fallIdx = -1;
    int          riseIdx = 0;
    int          startCount = 0;
    int          stopCount = 0;
    int          startBase = 0;
    int          stopBase = 0;
    vec_t        vecs[6];

    i2c_master_core_if bus();

    i2c_master_core dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    always #5 PCLK = ~PCLK;

    assign bus.sda_i = ~(bus.sda_oe | slavePull);
    assign bus.scl_i = bus.scl_o & ~stretch;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        nVec++;
        nMiss++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic monitorBus();
        logic prevScl = 1'b1;
        logic prevSda = 1'b1;
        logic e;
        int   cycle = 0;
        int   lastRise = 0;
        forever begin
            @(posedge PCLK);
            #1;
            cycle++;
            if (monEnable) begin
                if (!prevScl && bus.scl_o) begin
                    if (expQ.size() == 0) begin
                        nVec++;
                        nMiss++;
                        $display("[TB] FAIL sdaBit: got an SCL rise with SDA=%0b, expected no bit", bus.sda_i);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput($sformatf("sdaBit%0d", riseIdx), {31'b0, bus.sda_i}, {31'b0, e});
                    end
                    if (checkPeriod && riseIdx > 0) begin
                        checkOutput("bitPeriod", cycle - lastRise, 4 * (curPrescale + 1));
                    end
                    lastRise = cycle;
                    riseIdx++;
                end
                if (prevScl && !bus.scl_o) begin
                    fallIdx++;
                    slavePull = (fallIdx >= 0 && fallIdx < 32) ? pullMask[fallIdx[4:0]] : 1'b0;
                end
                if (prevScl && bus.scl_o && prevSda && !bus.sda_i) startCount++;
                if (prevScl && bus.scl_o && !prevSda && bus.sda_i) stopCount++;
            end
            prevScl = bus.scl_o;
            prevSda = bus.sda_i;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic isRead;
        logic nackExp;
        logic rxvExp;
        isRead = v.addr[0];
        bus.prescale_reg = v.prescale;
        bus.address_reg  = v.addr;
        bus.transmit_reg = v.tx;
        curPrescale      = v.prescale;
        pullMask         = '0;
        pullMask[8]      = v.ackAddr;
        for (int i = 7; i >= 0; i--) expQ.push_back(v.addr[i]);
        expQ.push_back(!v.ackAddr);
        if (v.ackAddr) begin
            if (isRead) begin
                for (int i = 0; i < 8; i++) pullMask[9 + i] = ~v.slaveByte[7 - i];
                for (int i = 7; i >= 0; i--) expQ.push_back(v.slaveByte[i]);
                expQ.push_back(1'b1);
            end else begin
                pullMask[17] = v.ackData;
                for (int i = 7; i >= 0; i--) expQ.push_back(v.tx[i]);
                expQ.push_back(!v.ackData);
            end
        end
        expQ.push_back(1'b0);
        nackExp = !v.ackAddr || (!isRead && !v.ackData);
        rxvExp  = isRead && v.ackAddr;
        if (rxvExp) lastRx = v.slaveByte;
        expStatus = {4'b0000, nackExp, 1'b0, 1'b1, rxvExp};
        fallIdx   = -1;
        riseIdx   = 0;
        startBase = startCount;
        stopBase  = stopCount;
        bus.command_reg = 8'h80;
        bus.cmd_wr = 1'b1;
        @(posedge PCLK);
        #2;
        bus.cmd_wr = 1'b0;
        checkOutput("statusAtAccept", bus.status_reg, 8'h04);
    endtask

    task automatic finishTransfer(input string tag);
        int n;
        n = 0;
        while (bus.status_reg[2] && n < 5000) begin
            @(posedge PCLK);
            #2;
            n++;
        end
        if (bus.status_reg[2]) timeoutFail({tag, "Done"});
        repeat (5) @(posedge PCLK);
        #2;
        checkOutput({tag, "Status"}, bus.status_reg, expStatus);
        checkOutput({tag, "Receive"}, bus.receive_reg, lastRx);
        checkOutput({tag, "Starts"}, startCount - startBase, 1);
        checkOutput({tag, "Stops"}, stopCount - stopBase, 1);
        checkOutput({tag, "BitsLeft"}, expQ.size(), 0);
    endtask

    initial begin
        int n;
        int highLen;
        int expHigh;
        vec_t v;

        vecs[0] = '{prescale: 8'd4, addr: 8'h40, tx: 8'h01, slaveByte: 8'h00, ackAddr: 1'b1, ackData: 1'b1};
        vecs[1] = '{prescale: 8'd4, addr: 8'h41, tx: 8'h00, slaveByte: 8'h02, ackAddr: 1'b1, ackData: 1'b1};
        vecs[2] = '{prescale: 8'd4, addr: 8'h40, tx: 8'h33, slaveByte: 8'h00, ackAddr: 1'b0, ackData: 1'b1};
        vecs[3] = '{prescale: 8'd0, addr: 8'hA4, tx: 8'h5A, slaveByte: 8'h00, ackAddr: 1'b1, ackData: 1'b0};
        vecs[4] = '{prescale: 8'd1, addr: 8'h55, tx: 8'h00, slaveByte: 8'hC3, ackAddr: 1'b1, ackData: 1'b1};
        vecs[5] = '{prescale: 8'd2, addr: 8'h7E, tx: 8'hFF, slaveByte: 8'h00, ackAddr: 1'b1, ackData: 1'b1};

        PRESET = 1'b1;
        bus.prescale_reg = 8'd4;
        bus.address_reg  = 8'h00;
        bus.transmit_reg = 8'h00;
        bus.command_reg  = 8'h00;
        bus.cmd_wr       = 1'b0;
        repeat (3) @(posedge PCLK);
        #2;
        checkOutput("resetStatus", bus.status_reg, 8'h00);
        checkOutput("resetReceive", bus.receive_reg, 8'h00);
        checkOutput("resetScl", {31'b0, bus.scl_o}, 1);
        checkOutput("resetSda", {31'b0, bus.sda_oe}, 0);
        PRESET = 1'b0;
        fork
            monitorBus();
        join_none
        repeat (2) @(posedge PCLK);
        #2;
        monEnable = 1'b1;

        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k]);
            finishTransfer($sformatf("vec%0d", k));
        end

        $display("[TB] busy rejection and register latching");
        applyStimulus(vecs[0]);
        repeat (60) @(posedge PCLK);
        #2;
        checkOutput("midBusy", {31'b0, bus.status_reg[2]}, 1);
        bus.transmit_reg = 8'hFF;
        bus.address_reg  = 8'h41;
        bus.cmd_wr = 1'b1;
        @(posedge PCLK);
        #2;
        bus.cmd_wr = 1'b0;
        finishTransfer("busyRej");
        repeat (100) @(posedge PCLK);
        #2;
        checkOutput("noSecondStart", startCount - startBase, 1);
        checkOutput("idleAfterReject", {31'b0, bus.status_reg[2]}, 0);

        $display("[TB] reset during write bit 3");
        v = '{prescale: 8'd2, addr: 8'h40, tx: 8'hA5, slaveByte: 8'h00, ackAddr: 1'b1, ackData: 1'b1};
        applyStimulus(v);
        n = 0;
        while (riseIdx < 13 && n < 2000) begin
            @(posedge PCLK);
            #2;
            n++;
        end
        if (riseIdx < 13) timeoutFail("reachWriteBit3");
        monEnable = 1'b0;
        PRESET = 1'b1;
        @(posedge PCLK);
        #2;
        checkOutput("abortScl", {31'b0, bus.scl_o}, 1);
        checkOutput("abortSda", {31'b0, bus.sda_oe}, 0);
        checkOutput("abortStatus", bus.status_reg, 8'h00);
        checkOutput("abortReceive", bus.receive_reg, 8'h00);
        PRESET = 1'b0;
        expQ.delete();
        lastRx = 8'h00;
        slavePull = 1'b0;
        fallIdx = -1;
        repeat (50) @(posedge PCLK);
        #2;
        checkOutput("abortStaysIdle", bus.status_reg, 8'h00);
        monEnable = 1'b1;

        $display("[TB] clock stretch in the first address bit");
        checkPeriod = 1'b0;
        applyStimulus(vecs[0]);
        n = 0;
        while (riseIdx < 1 && n < 500) begin
            @(posedge PCLK);
            #2;
            n++;
        end
        if (riseIdx < 1) timeoutFail("firstRise");
        stretch = 1'b1;
        highLen = 0;
        do begin
            @(posedge PCLK);
            #2;
            highLen++;
            if (highLen == 10) stretch = 1'b0;
        end while (bus.scl_o && highLen < 100);
        stretch = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
        expHigh = 20;
`else
        expHigh = 10;
`endif
        checkOutput("sclHighLen", highLen, expHigh);
        finishTransfer("stretch");
        checkPeriod = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end
endmodule
